// File: rtl/iter_mul_div_unit.sv
// iter_mul_div_unit: multi-cycle signed/unsigned multiply/divide, one result bit per clock
//   clk, rst_n (async, active-low)
//   start, op_div, unsigned_instr, op1, op2 : operation request, captured in IDLE
//   flush                                    : abort in-flight operation
//   busy, done                               : stall indicator and one-cycle completion pulse
//   hi, lo, div_by_zero                      : registered result, held until next completion
module iter_mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_div,
    input  logic             unsigned_instr,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t             state;
    logic [WIDTH-1:0]   b;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;
    logic               is_div, neg_res, neg_rem, dz;
    logic               s1, s2, div_ge;
    logic [WIDTH-1:0]   abs1, abs2, quo, rem;
    logic [WIDTH:0]     mul_sum, div_cand, div_diff;
    logic [2*WIDTH-1:0] acc_nxt, prod;
    always_comb begin
        s1       = !unsigned_instr && op1[WIDTH-1];
        s2       = !unsigned_instr && op2[WIDTH-1];
        abs1     = s1 ? -op1 : op1;
        abs2     = s2 ? -op2 : op2;
        // multiply: acc = {partial product, remaining multiplier bits}; the sum keeps its carry
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? b : '0};
        // divide: acc = {partial remainder, remaining dividend / growing quotient}
        div_cand = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff = div_cand - {1'b0, b};
        div_ge   = div_cand >= {1'b0, b};
        acc_nxt  = !is_div ? {mul_sum, acc[WIDTH-1:1]} :
                   div_ge  ? {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1} :
                             {div_cand[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        prod     = neg_res ? -acc : acc;
        quo      = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        // with a zero divisor the remainder ends up as |op1|, so re-signing restores raw op1
        rem      = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
            b           <= '0;
            acc         <= '0;
            cnt         <= '0;
            is_div      <= 1'b0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
            dz          <= 1'b0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        b       <= op_div ? abs2 : abs1;
                        acc     <= {{WIDTH{1'b0}}, op_div ? abs1 : abs2};
                        neg_res <= s1 ^ s2;
                        neg_rem <= s1;
                        is_div  <= op_div;
                        dz      <= op_div && (op2 == '0);
                        cnt     <= CNT_W'(WIDTH);
                        busy    <= 1'b1;
                        state   <= CALC;
                    end
                    CALC: begin
                        acc <= acc_nxt;
                        cnt <= cnt - 1'b1;
                        if (cnt == CNT_W'(1)) state <= FIX;
                    end
                    FIX: begin
                        hi          <= is_div ? rem : prod[2*WIDTH-1:WIDTH];
                        lo          <= is_div ? (dz ? '1 : quo) : prod[WIDTH-1:0];
                        div_by_zero <= dz;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_iter_mul_div_unit.sv
// tb_iter_mul_div_unit: directed self-checking bench for iter_mul_div_unit (WIDTH 32 and 16)
module tb_iter_mul_div_unit;
    logic        clk = 1'b0, rst_n = 1'b0, rst16_n = 1'b0;
    logic        start = 1'b0, start16 = 1'b0, op_div = 1'b0, uns = 1'b0, flush = 1'b0;
    logic [31:0] op1 = '0, op2 = '0;
    logic [15:0] op1_16 = '0, op2_16 = '0;
    logic        busy, done, dz, busy16, done16, dz16;
    logic [31:0] hi, lo;
    logic [15:0] hi16, lo16;
    int          checks = 0, errors = 0, busy_cnt = 0;
    typedef struct packed {
        logic        d, u;
        logic [31:0] x, y, h, l;
        logic        z;
    } vec_t;
    vec_t tab[8];
    always #5 clk = ~clk;
    iter_mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_div(op_div), .unsigned_instr(uns),
        .op1(op1), .op2(op2), .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo),
        .div_by_zero(dz)
    );
    iter_mul_div_unit #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst16_n), .start(start16), .op_div(op_div), .unsigned_instr(uns),
        .op1(op1_16), .op2(op2_16), .flush(flush), .busy(busy16), .done(done16), .hi(hi16),
        .lo(lo16), .div_by_zero(dz16)
    );
    task automatic wait_done(inout int lat);
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (busy) busy_cnt++;
        end
    endtask
    task automatic do_op(input logic d, u, input logic [31:0] x, y, output int lat);
        op_div = d; uns = u; op1 = x; op2 = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; lat = 0; busy_cnt = busy ? 1 : 0;
        wait_done(lat);
    endtask
    task automatic test_reset;
        #12;
        checks++; if ({busy, done, dz} !== 3'b000) begin errors++; $display("FAIL reset_ctl: got %b exp 000", {busy, done, dz}); end
        checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL reset_hilo: got %h exp 0", {hi, lo}); end
        checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL reset_busy16: got %b exp 0", busy16); end
        #11 rst_n = 1'b1; rst16_n = 1'b1;
        @(posedge clk); #1;
    endtask
    task automatic test_vectors(input int first, input int last);
        int lat;
        for (int i = first; i <= last; i++) begin
            do_op(tab[i].d, tab[i].u, tab[i].x, tab[i].y, lat);
            checks++; if (lat !== 33) begin errors++; $display("FAIL vec%0d_latency: got %0d exp 33", i, lat); end
            checks++; if (busy_cnt !== 33) begin errors++; $display("FAIL vec%0d_busy_cycles: got %0d exp 33", i, busy_cnt); end
            checks++; if (hi !== tab[i].h) begin errors++; $display("FAIL vec%0d_hi: got %h exp %h", i, hi, tab[i].h); end
            checks++; if (lo !== tab[i].l) begin errors++; $display("FAIL vec%0d_lo: got %h exp %h", i, lo, tab[i].l); end
            checks++; if (dz !== tab[i].z) begin errors++; $display("FAIL vec%0d_dz: got %b exp %b", i, dz, tab[i].z); end
        end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got %b exp 0", done); end
        checks++; if (lo !== tab[last].l) begin errors++; $display("FAIL lo_hold: got %h exp %h", lo, tab[last].l); end
    endtask
    task automatic test_start_while_busy;
        int lat = 0, extra = 0;
        op_div = 1'b0; uns = 1'b1; op1 = 32'd7; op2 = 32'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; lat++; end
        op1 = 32'd100; op2 = 32'd100; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; lat++;
        wait_done(lat);
        checks++; if (lat !== 33) begin errors++; $display("FAIL busy_start_latency: got %0d exp 33", lat); end
        checks++; if (lo !== 32'h2A) begin errors++; $display("FAIL busy_start_lo: got %h exp 0000002a", lo); end
        repeat (40) begin @(posedge clk); #1; if (done || busy) extra++; end
        checks++; if (extra !== 0) begin errors++; $display("FAIL busy_start_second_op: got %0d active cycles exp 0", extra); end
    endtask
    task automatic test_flush;
        int extra = 0;
        logic [31:0] h0, l0;
        h0 = hi; l0 = lo;
        op_div = 1'b0; uns = 1'b1; op1 = 32'd5; op2 = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b exp 0", busy); end
        flush = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_start_busy: got %b exp 0", busy); end
        repeat (40) begin @(posedge clk); #1; if (done) extra++; end
        checks++; if (extra !== 0) begin errors++; $display("FAIL flush_done: got %0d pulses exp 0", extra); end
        checks++; if ({hi, lo} !== {h0, l0}) begin errors++; $display("FAIL flush_hilo: got %h exp %h", {hi, lo}, {h0, l0}); end
    endtask
    task automatic test_back_to_back;
        int lat;
        do_op(1'b0, 1'b1, 32'd2, 32'd3, lat);
        checks++; if (lo !== 32'd6) begin errors++; $display("FAIL b2b_first_lo: got %h exp 00000006", lo); end
        do_op(1'b0, 1'b1, 32'd4, 32'd5, lat);
        checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_latency: got %0d exp 33", lat); end
        checks++; if (lo !== 32'h14) begin errors++; $display("FAIL b2b_second_lo: got %h exp 00000014", lo); end
    endtask
    task automatic test_reset_midop;
        int lat = 0;
        op_div = 1'b0; uns = 1'b1; op1 = 32'd7; op2 = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({busy, done, dz} !== 3'b000) begin errors++; $display("FAIL midrst_ctl: got %b exp 000", {busy, done, dz}); end
        checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL midrst_hilo: got %h exp 0", {hi, lo}); end
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(1'b0, 1'b1, 32'd9, 32'd9, lat);
        checks++; if (lat !== 33) begin errors++; $display("FAIL midrst_latency: got %0d exp 33", lat); end
        checks++; if ({hi, lo} !== 64'h51) begin errors++; $display("FAIL midrst_result: got %h exp 51", {hi, lo}); end
    endtask
    task automatic test_width16;
        int lat = 0;
        op_div = 1'b0; uns = 1'b1; op1_16 = 16'd7; op2_16 = 16'd7; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        #2 rst16_n = 1'b0;
        #1;
        checks++; if ({busy16, done16, hi16, lo16} !== 34'h0) begin errors++; $display("FAIL w16_midrst: got %h exp 0", {busy16, done16, hi16, lo16}); end
        #3 rst16_n = 1'b1;
        @(posedge clk); #1;
        op1_16 = 16'd9; op2_16 = 16'd9; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        while (!done16 && lat < 100) begin @(posedge clk); #1; lat++; end
        checks++; if (lat !== 17) begin errors++; $display("FAIL w16_latency: got %0d exp 17", lat); end
        checks++; if ({hi16, lo16} !== 32'h51) begin errors++; $display("FAIL w16_result: got %h exp 51", {hi16, lo16}); end
        checks++; if (dz16 !== 1'b0) begin errors++; $display("FAIL w16_dz: got %b exp 0", dz16); end
    endtask
    initial begin
        tab[0] = '{1'b0, 1'b1, 32'd7,        32'd6,        32'h00000000, 32'h0000002A, 1'b0};
        tab[1] = '{1'b0, 1'b0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
        tab[2] = '{1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        tab[3] = '{1'b1, 1'b0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        tab[4] = '{1'b1, 1'b1, 32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, 1'b0};
        tab[5] = '{1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        tab[6] = '{1'b1, 1'b0, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 1'b1};
        tab[7] = '{1'b0, 1'b1, 32'd3,        32'd4,        32'h00000000, 32'h0000000C, 1'b0};
        test_reset;
        test_vectors(0, 2);
        test_vectors(3, 7);
        test_start_while_busy;
        test_flush;
        test_back_to_back;
        test_reset_midop;
        test_width16;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
